// File: rtl/cdb_arbiter_pkg.sv
// =============================================================================
// Module  : cdb_arbiter_pkg
// Purpose : Shared widths and CDB source encoding for the CDB writeback arbiter.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package cdb_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_ROB_W  = 4;
    localparam int DEF_DEPTH  = 2;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSU = 1'b1
    } cdb_src_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// =============================================================================
// Module  : cdb_arbiter_if
// Purpose : Requester and CDB handshake bundle for the CDB writeback arbiter.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ROB_W  = 4
);
    logic              alu_valid_in;
    logic              alu_ready_out;
    logic [ROB_W-1:0]  alu_reorder_in;
    logic [DATA_W-1:0] alu_value_in;
    logic [ADDR_W-1:0] alu_pc_in;

    logic              lsu_valid_in;
    logic              lsu_ready_out;
    logic [ROB_W-1:0]  lsu_reorder_in;
    logic [DATA_W-1:0] lsu_value_in;

    logic              cdb_valid_out;
    logic              cdb_ready_in;
    logic [ROB_W-1:0]  cdb_reorder_out;
    logic [DATA_W-1:0] cdb_value_out;
    logic [ADDR_W-1:0] cdb_pc_out;
    cdb_src_e          cdb_src_out;

    // Arbiter side
    modport slave (
        input  alu_valid_in, alu_reorder_in, alu_value_in, alu_pc_in,
        input  lsu_valid_in, lsu_reorder_in, lsu_value_in,
        input  cdb_ready_in,
        output alu_ready_out, lsu_ready_out,
        output cdb_valid_out, cdb_reorder_out, cdb_value_out, cdb_pc_out, cdb_src_out
    );

    // Execution units and ROB side
    modport master (
        output alu_valid_in, alu_reorder_in, alu_value_in, alu_pc_in,
        output lsu_valid_in, lsu_reorder_in, lsu_value_in,
        output cdb_ready_in,
        input  alu_ready_out, lsu_ready_out,
        input  cdb_valid_out, cdb_reorder_out, cdb_value_out, cdb_pc_out, cdb_src_out
    );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_wb_fifo.sv
// =============================================================================
// Module  : wb_fifo
// Purpose : Small result FIFO with synchronous clear; head is read combinationally.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// =============================================================================
// Module  : cdb_arbiter
// Purpose : Round-robin arbiter of ALU/LSU results onto a registered CDB stage.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  wire logic    clk_in,
    input  wire logic    rst_in,
    input  wire logic    rdy_in,
    input  wire logic    flush_in,
    cdb_arbiter_if.slave bus
);
    localparam int ALU_W = ROB_W + DATA_W + ADDR_W;
    localparam int LSU_W = ROB_W + DATA_W;

    logic             alu_full, alu_empty, lsu_full, lsu_empty;
    logic [ALU_W-1:0] alu_head;
    logic [LSU_W-1:0] lsu_head;
    logic             accept, clear, stage_free, any_pending, grant;
    logic             alu_push, lsu_push, alu_pop, lsu_pop;
    cdb_src_e         prio, grant_src;

    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_reorder;
    logic [DATA_W-1:0] cdb_value;
    logic [ADDR_W-1:0] cdb_pc;
    cdb_src_e          cdb_src;

    assign accept = rdy_in & ~flush_in;
    assign clear  = rdy_in & flush_in;

    // Ready looks only at fullness: a pop in the same cycle does not open a slot
    assign bus.alu_ready_out = accept & ~alu_full;
    assign bus.lsu_ready_out = accept & ~lsu_full;
    assign alu_push = bus.alu_valid_in & bus.alu_ready_out;
    assign lsu_push = bus.lsu_valid_in & bus.lsu_ready_out;

    assign stage_free  = ~cdb_valid | bus.cdb_ready_in;
    assign any_pending = ~alu_empty | ~lsu_empty;
    assign grant       = accept & stage_free & any_pending;

    always_comb begin
        grant_src = prio;
        if (alu_empty)      grant_src = CDB_SRC_LSU;
        else if (lsu_empty) grant_src = CDB_SRC_ALU;
    end

    assign alu_pop = grant & (grant_src == CDB_SRC_ALU);
    assign lsu_pop = grant & (grant_src == CDB_SRC_LSU);

    wb_fifo #(.WIDTH(ALU_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (alu_push),
        .pop   (alu_pop),
        .clear (clear),
        .din   ({bus.alu_reorder_in, bus.alu_value_in, bus.alu_pc_in}),
        .full  (alu_full),
        .empty (alu_empty),
        .head  (alu_head)
    );

    wb_fifo #(.WIDTH(LSU_W), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (lsu_push),
        .pop   (lsu_pop),
        .clear (clear),
        .din   ({bus.lsu_reorder_in, bus.lsu_value_in}),
        .full  (lsu_full),
        .empty (lsu_empty),
        .head  (lsu_head)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid   <= 1'b0;
            cdb_reorder <= '0;
            cdb_value   <= '0;
            cdb_pc      <= '0;
            cdb_src     <= CDB_SRC_ALU;
            prio        <= CDB_SRC_ALU;
        end else if (rdy_in) begin
            if (flush_in) begin
                cdb_valid <= 1'b0;
                prio      <= CDB_SRC_ALU;
            end else if (stage_free) begin
                if (any_pending) begin
                    cdb_valid <= 1'b1;
                    cdb_src   <= grant_src;
                    prio      <= (grant_src == CDB_SRC_ALU) ? CDB_SRC_LSU : CDB_SRC_ALU;
                    if (grant_src == CDB_SRC_ALU) begin
                        {cdb_reorder, cdb_value, cdb_pc} <= alu_head;
                    end else begin
                        {cdb_reorder, cdb_value} <= lsu_head;
                        cdb_pc                   <= '0;
                    end
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.cdb_valid_out   = cdb_valid;
    assign bus.cdb_reorder_out = cdb_reorder;
    assign bus.cdb_value_out   = cdb_value;
    assign bus.cdb_pc_out      = cdb_pc;
    assign bus.cdb_src_out     = cdb_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// =============================================================================
// Module  : tb_cdb_arbiter
// Purpose : Self-checking bench for cdb_arbiter (vector table, corner sequences, random).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ROB_W  = 4;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_in;

    cdb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_W(ROB_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, flush, av;
        logic [3:0]  at;
        logic [31:0] aval, apc;
        logic        lv;
        logic [3:0]  lt;
        logic [31:0] lval;
        logic        cr;
    } in_t;

    typedef struct {
        in_t         in;
        logic        ev;
        logic [3:0]  et;
        logic [31:0] evl, ep;
        logic        es, ear, elr;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val, pc;
    } ent_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: two result queues and the CDB register contents
    ent_t        alu_q[$];
    ent_t        lsu_q[$];
    logic        m_v, m_src, m_pref;
    logic [3:0]  m_tag;
    logic [31:0] m_val, m_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(logic av, logic [3:0] at, logic [31:0] aval, logic [31:0] apc,
                                  logic lv, logic [3:0] lt, logic [31:0] lval, logic cr);
        in_t r;
        r.rdy = 1'b1; r.flush = 1'b0;
        r.av = av; r.at = at; r.aval = aval; r.apc = apc;
        r.lv = lv; r.lt = lt; r.lval = lval; r.cr = cr;
        return r;
    endfunction

    function automatic vec_t mk_vec(in_t i, logic ev, logic [3:0] et, logic [31:0] evl,
                                    logic [31:0] ep, logic es, logic ear, logic elr);
        vec_t r;
        r.in = i; r.ev = ev; r.et = et; r.evl = evl; r.ep = ep; r.es = es; r.ear = ear; r.elr = elr;
        return r;
    endfunction

    function automatic void model_reset();
        alu_q.delete(); lsu_q.delete();
        m_v = 1'b0; m_src = 1'b0; m_pref = 1'b0;
        m_tag = '0; m_val = '0; m_pc = '0;
    endfunction

    function automatic void model_step(in_t v);
        logic push_a, push_l, src;
        ent_t e, na, nl;
        if (!v.rdy) return;
        if (v.flush) begin
            alu_q.delete(); lsu_q.delete();
            m_v = 1'b0; m_pref = 1'b0;
            return;
        end
        push_a = v.av && (alu_q.size() < DEPTH);
        push_l = v.lv && (lsu_q.size() < DEPTH);
        if (!m_v || v.cr) begin
            if (alu_q.size() > 0 || lsu_q.size() > 0) begin
                if (alu_q.size() > 0 && lsu_q.size() > 0) src = m_pref;
                else src = (alu_q.size() > 0) ? 1'b0 : 1'b1;
                e = src ? lsu_q.pop_front() : alu_q.pop_front();
                m_v = 1'b1; m_src = src; m_tag = e.tag; m_val = e.val; m_pc = e.pc;
                m_pref = ~src;
            end else begin
                m_v = 1'b0;
            end
        end
        na.tag = v.at; na.val = v.aval; na.pc = v.apc;
        nl.tag = v.lt; nl.val = v.lval; nl.pc = '0;
        if (push_a) alu_q.push_back(na);
        if (push_l) lsu_q.push_back(nl);
    endfunction

    task automatic drive(input in_t v);
        rdy_in               = v.rdy;
        flush_in             = v.flush;
        bus.alu_valid_in     = v.av;
        bus.alu_reorder_in   = v.at;
        bus.alu_value_in     = v.aval;
        bus.alu_pc_in        = v.apc;
        bus.lsu_valid_in     = v.lv;
        bus.lsu_reorder_in   = v.lt;
        bus.lsu_value_in     = v.lval;
        bus.cdb_ready_in     = v.cr;
    endtask

    // Drive at the falling edge, then compare the DUT against the model 1ns later
    task automatic drive_check(input in_t v);
        drive(v);
        #1;
        chk("alu_ready", bus.alu_ready_out, v.rdy && !v.flush && (alu_q.size() < DEPTH));
        chk("lsu_ready", bus.lsu_ready_out, v.rdy && !v.flush && (lsu_q.size() < DEPTH));
        chk("cdb_valid", bus.cdb_valid_out, m_v);
        if (m_v) begin
            chk("cdb_tag",   bus.cdb_reorder_out, m_tag);
            chk("cdb_value", bus.cdb_value_out,   m_val);
            chk("cdb_pc",    bus.cdb_pc_out,      m_pc);
            chk("cdb_src",   bus.cdb_src_out,     m_src);
        end
    endtask

    task automatic finish_cycle(input in_t v);
        model_step(v);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input in_t v);
        drive_check(v);
        finish_cycle(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        in_t  idle, iv;

        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[0] = mk_vec(mk_in(1, 4'd3, 32'h11, 32'h80, 0, 0, 0, 1),         0, 0, 0, 0, 0, 1, 1);
        tbl[1] = mk_vec(idle,                                                0, 0, 0, 0, 0, 1, 1);
        tbl[2] = mk_vec(mk_in(1, 4'd1, 32'h21, 32'h100, 1, 4'd9, 32'h91, 1),  1, 4'd3, 32'h11, 32'h80, 0, 1, 1);
        tbl[3] = mk_vec(mk_in(1, 4'd2, 32'h22, 32'h104, 1, 4'd10, 32'h92, 1), 0, 0, 0, 0, 0, 1, 1);
        tbl[4] = mk_vec(idle,                                                1, 4'd9,  32'h91, 32'h0,   1, 0, 1);
        tbl[5] = mk_vec(idle,                                                1, 4'd1,  32'h21, 32'h100, 0, 1, 1);
        tbl[6] = mk_vec(idle,                                                1, 4'd10, 32'h92, 32'h0,   1, 1, 1);
        tbl[7] = mk_vec(idle,                                                1, 4'd2,  32'h22, 32'h104, 0, 1, 1);
        tbl[8] = mk_vec(idle,                                                0, 0, 0, 0, 0, 1, 1);

        // Reset state
        rst_in = 1'b0;
        drive(idle);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.cdb_valid_out,   1'b0);
        chk("rst_tag",   bus.cdb_reorder_out, 4'd0);
        chk("rst_value", bus.cdb_value_out,   32'd0);
        chk("rst_pc",    bus.cdb_pc_out,      32'd0);
        chk("rst_src",   bus.cdb_src_out,     1'b0);
        rst_in = 1'b1;

        // Latency and alternation vectors
        for (int i = 0; i < 9; i++) begin
            drive_check(tbl[i].in);
            chk($sformatf("tbl%0d_valid", i), bus.cdb_valid_out, tbl[i].ev);
            chk($sformatf("tbl%0d_aready", i), bus.alu_ready_out, tbl[i].ear);
            chk($sformatf("tbl%0d_lready", i), bus.lsu_ready_out, tbl[i].elr);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_tag", i),   bus.cdb_reorder_out, tbl[i].et);
                chk($sformatf("tbl%0d_value", i), bus.cdb_value_out,   tbl[i].evl);
                chk($sformatf("tbl%0d_pc", i),    bus.cdb_pc_out,      tbl[i].ep);
                chk($sformatf("tbl%0d_src", i),   bus.cdb_src_out,     tbl[i].es);
            end
            finish_cycle(tbl[i].in);
        end

        // Back-pressure: CDB held while LSU keeps offering
        apply(mk_in(0, 0, 0, 0, 1, 4'd5, 32'h55, 1));
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            iv = mk_in(0, 0, 0, 0, 1, 4'(6 + k), 32'h60 + k, 0);
            drive_check(iv);
            chk("hold_tag",   bus.cdb_reorder_out, 4'd5);
            chk("hold_value", bus.cdb_value_out,   32'h55);
            chk("hold_valid", bus.cdb_valid_out,   1'b1);
            if (k >= 2) chk("hold_lsu_full", bus.lsu_ready_out, 1'b0);
            finish_cycle(iv);
        end
        for (int k = 0; k < 4; k++) apply(idle);

        // Flush with both FIFOs full and the CDB valid
        apply(mk_in(1, 4'd1, 32'hA1, 32'h200, 1, 4'd8, 32'hB8, 0));
        apply(mk_in(1, 4'd2, 32'hA2, 32'h204, 1, 4'd9, 32'hB9, 0));
        apply(mk_in(1, 4'd3, 32'hA3, 32'h208, 1, 4'd10, 32'hBA, 0));
        chk("preflush_alu_n", alu_q.size(), 2);
        chk("preflush_lsu_n", lsu_q.size(), 2);
        iv = mk_in(1, 4'd4, 32'hA4, 32'h20C, 1, 4'd11, 32'hBB, 0);
        iv.flush = 1'b1;
        apply(iv);
        drive_check(idle);
        chk("flush_valid",  bus.cdb_valid_out, 1'b0);
        chk("flush_aready", bus.alu_ready_out, 1'b1);
        chk("flush_lready", bus.lsu_ready_out, 1'b1);
        finish_cycle(idle);
        drive_check(idle);
        chk("flush_no_push", bus.cdb_valid_out, 1'b0);
        finish_cycle(idle);

        // rdy_in low mid-stream freezes everything
        apply(mk_in(1, 4'd5, 32'hC5, 32'h300, 1, 4'd12, 32'hDC, 1));
        apply(mk_in(1, 4'd6, 32'hC6, 32'h304, 1, 4'd13, 32'hDD, 1));
        for (int k = 0; k < 3; k++) begin
            iv = mk_in(1, 4'd7, 32'hC7, 32'h308, 1, 4'd14, 32'hDE, 1);
            iv.rdy = 1'b0;
            apply(iv);
        end
        for (int k = 0; k < 6; k++) apply(idle);

        // Asynchronous reset pulse while the CDB is valid
        apply(mk_in(1, 4'd7, 32'h77, 32'h400, 0, 0, 0, 0));
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));
        chk("pre_rst_valid", bus.cdb_valid_out, 1'b1);
        drive(idle);
        rst_in = 1'b0;
        #1;
        chk("async_rst_valid", bus.cdb_valid_out,   1'b0);
        chk("async_rst_tag",   bus.cdb_reorder_out, 4'd0);
        #1;
        rst_in = 1'b1;
        model_reset();
        finish_cycle(idle);
        apply(mk_in(1, 4'd1, 32'hE1, 32'h500, 1, 4'd2, 32'hE2, 1));
        apply(idle);
        drive_check(idle);
        chk("post_rst_first_src", bus.cdb_src_out, 1'b0);
        chk("post_rst_first_tag", bus.cdb_reorder_out, 4'd1);
        finish_cycle(idle);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            iv.rdy   = ($urandom % 10) != 0;
            iv.flush = ($urandom % 25) == 0;
            iv.av    = 1'($urandom);
            iv.at    = 4'($urandom);
            iv.aval  = $urandom;
            iv.apc   = $urandom;
            iv.lv    = 1'($urandom);
            iv.lt    = 4'($urandom);
            iv.lval  = $urandom;
            iv.cr    = ($urandom % 4) != 0;
            apply(iv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
